// File: rtl/sample_player.sv
// Sample player: plays a pattern from a 2^ADDR_W x DATA_W buffer, in loop or
// one-shot mode, through a valid/ready output stage with backpressure.
module sample_player #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              start,
  input  logic              stop,
  input  logic              mode,
  input  logic [ADDR_W-1:0] last_addr,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  loop_cnt
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t              state_q;
  logic [ADDR_W-1:0]   rd_addr_q;
  logic [ADDR_W-1:0]   last_q;
  logic                mode_q;
  logic [DATA_W-1:0]   out_data_q;
  logic                out_valid_q;
  logic                done_q;
  logic [CNT_W-1:0]    loop_cnt_q;
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic                load;

  // A new sample is fetched whenever the output register is empty or draining
  always_comb begin
    load = (state_q == RUN) && (!out_valid_q || out_ready);
  end

  // Pattern buffer: written in any state, never reset so contents survive reset
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  // Playback FSM with registered outputs; a same-edge write is not seen by the read
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      rd_addr_q   <= '0;
      last_q      <= '0;
      mode_q      <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
      loop_cnt_q  <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start && !stop) begin
            state_q     <= RUN;
            rd_addr_q   <= '0;
            mode_q      <= mode;
            last_q      <= last_addr;
            loop_cnt_q  <= '0;
            out_valid_q <= 1'b0;
          end
        end
        RUN: begin
          if (stop) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
          end else if (load) begin
            out_data_q  <= mem_q[rd_addr_q];
            out_valid_q <= 1'b1;
            if (rd_addr_q == last_q) begin
              if (mode_q) begin
                state_q <= FLUSH;
              end else begin
                rd_addr_q <= '0;
                if (loop_cnt_q != '1) begin
                  loop_cnt_q <= loop_cnt_q + 1'b1;
                end
              end
            end else begin
              rd_addr_q <= rd_addr_q + 1'b1;
            end
          end
        end
        FLUSH: begin
          if (stop) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
          end else if (out_valid_q && out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            done_q      <= 1'b1;
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = (state_q != IDLE);
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign done      = done_q;
  assign loop_cnt  = loop_cnt_q;

endmodule
